stream_reader: RTL and testbench

STREAM_READER -- requirements
Module: stream_reader

---
 rtl/stream_reader_if.sv | 57 +++++
 rtl/stream_reader.sv | 254 +++++++++++++++++++++++++
 tb/tb_stream_reader.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_reader_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces used by stream_reader.
//
// metaIntf : valid/ready metadata channel. It carries read requests (sq_rd),
//            completions (cq_rd) and interrupt notifications (notify). One
//            field set covers all three uses; fields a given use does not
//            need are driven to zero by the master.
//   modport m : master drives valid and all fields, samples ready.
//   modport s : slave samples valid and all fields, drives ready.
//
// AXI4S    : AXI4-Stream data channel (tdata/tkeep/tlast/tvalid/tready).
//   modport m : master drives tdata/tkeep/tlast/tvalid, samples tready.
//   modport s : slave samples tdata/tkeep/tlast/tvalid, drives tready.
// -----------------------------------------------------------------------------
interface metaIntf #(
    parameter int VADDR_BITS = 48,
    parameter int LEN_BITS   = 28
);
    logic                  valid;
    logic                  ready;
    logic [4:0]            opcode;
    logic [1:0]            strm;
    logic [3:0]            dest;
    logic [5:0]            pid;
    logic                  mode;
    logic                  rdma;
    logic                  remote;
    logic                  last;
    logic [VADDR_BITS-1:0] vaddr;
    logic [LEN_BITS-1:0]   len;
    logic [31:0]           value;

    modport m (
        output valid, opcode, strm, dest, pid, mode, rdma, remote, last,
               vaddr, len, value,
        input  ready
    );

    modport s (
        input  valid, opcode, strm, dest, pid, mode, rdma, remote, last,
               vaddr, len, value,
        output ready
    );
endinterface

interface AXI4S #(
    parameter int DATA_BITS = 512
);
    logic [DATA_BITS-1:0]   tdata;
    logic [DATA_BITS/8-1:0] tkeep;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;

    modport m (output tdata, tkeep, tlast, tvalid, input tready);
    modport s (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/stream_reader.sv
// -----------------------------------------------------------------------------
// stream_reader
//
// Accepts a job (base address + byte length), splits it into read requests of
// at most TRANSFER_LENGTH bytes on sq_rd while keeping no more than
// MAX_OUTSTANDING requests uncompleted, counts matching completions on cq_rd,
// and forwards returned data from i_data to o_data with zero latency. o_data
// tlast is regenerated from the job length; the host's tlast is not used.
//
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   i_vaddr, i_len  job base address and length in bytes (multiple of 64)
//   i_job_valid     job offered / o_job_ready job accepted (in IDLE)
//   o_bytes_read    cumulative bytes forwarded (kept across jobs)
//   o_busy          a job is in progress
//   sq_rd  (m)      read requests
//   cq_rd  (s)      completions
//   notify (m)      end-of-job interrupt
//   i_data (s)      data returned by the host
//   o_data (m)      data delivered to the user
//
// Build option:
//   STREAM_READER_NOTIFY_EN  when defined, each job ends with an interrupt on
//                            notify (held until accepted); otherwise the job
//                            returns straight to IDLE and notify is idle.
// -----------------------------------------------------------------------------
module stream_reader #(
    parameter logic [1:0]  STRM            = 2'd0,   // STRM_HOST: host stream
    parameter logic [3:0]  DEST            = 4'd0,
    parameter logic [31:0] IRQ_VALUE       = 32'd72,
    parameter bit          IS_LOCAL        = 1'b1,
    parameter int          TRANSFER_LENGTH = 4096,
    parameter int          MAX_OUTSTANDING = 8,
    parameter int          VADDR_BITS      = 48,
    parameter int          LEN_BITS        = 28
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [VADDR_BITS-1:0] i_vaddr,
    input  logic [VADDR_BITS-1:0] i_len,
    input  logic                  i_job_valid,
    output logic                  o_job_ready,
    output logic [VADDR_BITS-1:0] o_bytes_read,
    output logic                  o_busy,
    metaIntf.m                    sq_rd,
    metaIntf.s                    cq_rd,
    metaIntf.m                    notify,
    AXI4S.s                       i_data,
    AXI4S.m                       o_data
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0]      OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [VADDR_BITS-1:0] XFER_LEN = VADDR_BITS'(TRANSFER_LENGTH);

    localparam logic [4:0] OPC_LOCAL_READ = 5'd1;
    localparam logic [4:0] OPC_RDMA_READ  = 5'd6;
    localparam logic [4:0] RD_OPCODE      = IS_LOCAL ? OPC_LOCAL_READ : OPC_RDMA_READ;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_NOTIFY  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [VADDR_BITS-1:0]  vaddr_q, vaddr_d;
    logic [VADDR_BITS-1:0]  len_q, len_d;
    logic [VADDR_BITS-1:0]  remaining_q, remaining_d;
    logic [VADDR_BITS-1:0]  forwarded_q, forwarded_d;
    logic [VADDR_BITS-1:0]  bytes_read_q, bytes_read_d;
    logic [OUT_W-1:0]       outstanding_q, outstanding_d;
    logic                   final_seen_q, final_seen_d;

    logic                   in_idle;
    logic                   req_fire;
    logic                   cpl_hit;
    logic                   beat_fire;
    logic                   last_beat;
    logic                   drain_done;
    logic [VADDR_BITS-1:0]  req_len;
    logic [VADDR_BITS-1:0]  beat_bytes;
    logic [VADDR_BITS-1:0]  fwd_sum;

    // Handshake and datapath helpers
    always_comb begin
        in_idle    = (state_q == ST_IDLE);
        req_fire   = sq_rd.valid && sq_rd.ready;
        cpl_hit    = cq_rd.valid && (cq_rd.opcode == RD_OPCODE) &&
                     (cq_rd.strm == STRM) && (cq_rd.dest == DEST);
        beat_fire  = o_data.tvalid && o_data.tready;
        req_len    = (remaining_q < XFER_LEN) ? remaining_q : XFER_LEN;
        beat_bytes = VADDR_BITS'($countones(i_data.tkeep));
        fwd_sum    = forwarded_q + beat_bytes;
        last_beat  = (fwd_sum == len_q);
    end

    // Job bookkeeping: address/length walk, outstanding count, byte counters
    always_comb begin
        vaddr_d       = vaddr_q;
        len_d         = len_q;
        remaining_d   = remaining_q;
        forwarded_d   = forwarded_q;
        bytes_read_d  = bytes_read_q;
        outstanding_d = outstanding_q;
        final_seen_d  = final_seen_q;

        if (in_idle && i_job_valid) begin
            vaddr_d      = i_vaddr;
            len_d        = i_len;
            remaining_d  = i_len;
            forwarded_d  = '0;
            final_seen_d = 1'b0;
        end

        if (req_fire) begin
            vaddr_d     = vaddr_q + req_len;
            remaining_d = remaining_q - req_len;
        end

        if (beat_fire) begin
            forwarded_d  = fwd_sum;
            bytes_read_d = bytes_read_q + beat_bytes;
            if (last_beat) begin
                final_seen_d = 1'b1;
            end
        end

        // Issue and completion together cancel out; a completion with nothing
        // outstanding (e.g. one that was in flight across a reset) is dropped.
        case ({req_fire, cpl_hit})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase

        // The final beat and the last completion may land in either order or
        // in the same cycle, so look at this cycle's updates as well.
        drain_done = (outstanding_d == '0) &&
                     (final_seen_q || (beat_fire && last_beat));
    end

    // FSM: state register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_job_valid) state_d = ST_REQUEST;
            end
            ST_REQUEST: begin
                if (req_fire && (remaining_d == '0)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_done) begin
`ifdef STREAM_READER_NOTIFY_EN
                    state_d = ST_NOTIFY;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_NOTIFY: begin
`ifdef STREAM_READER_NOTIFY_EN
                if (notify.ready) state_d = ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_job_ready  = in_idle;
        o_busy       = !in_idle;
        o_bytes_read = bytes_read_q;

        sq_rd.valid  = (state_q == ST_REQUEST) && (remaining_q != '0) &&
                       (outstanding_q < OUT_MAX);
        sq_rd.opcode = RD_OPCODE;
        sq_rd.strm   = STRM;
        sq_rd.dest   = DEST;
        sq_rd.pid    = '0;
        sq_rd.mode   = ~IS_LOCAL;
        sq_rd.rdma   = ~IS_LOCAL;
        sq_rd.remote = ~IS_LOCAL;
        sq_rd.last   = 1'b1;
        sq_rd.vaddr  = vaddr_q;
        sq_rd.len    = LEN_BITS'(req_len);
        sq_rd.value  = '0;

        cq_rd.ready  = 1'b1;

`ifdef STREAM_READER_NOTIFY_EN
        notify.valid = (state_q == ST_NOTIFY);
`else
        notify.valid = 1'b0;
`endif
        notify.opcode = '0;
        notify.strm   = '0;
        notify.dest   = '0;
        notify.pid    = '0;
        notify.mode   = 1'b0;
        notify.rdma   = 1'b0;
        notify.remote = 1'b0;
        notify.last   = 1'b0;
        notify.vaddr  = '0;
        notify.len    = '0;
        notify.value  = IRQ_VALUE;

        // Zero-latency passthrough, closed while IDLE. The host's tlast is
        // deliberately unused: tlast is rebuilt from the job length.
        o_data.tdata  = i_data.tdata;
        o_data.tkeep  = i_data.tkeep;
        o_data.tvalid = i_data.tvalid && !in_idle;
        o_data.tlast  = i_data.tvalid && !in_idle && last_beat;
        i_data.tready = o_data.tready && !in_idle;
    end

    // Control counters (cleared by reset)
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            remaining_q   <= '0;
            forwarded_q   <= '0;
            bytes_read_q  <= '0;
            outstanding_q <= '0;
            final_seen_q  <= 1'b0;
        end else begin
            remaining_q   <= remaining_d;
            forwarded_q   <= forwarded_d;
            bytes_read_q  <= bytes_read_d;
            outstanding_q <= outstanding_d;
            final_seen_q  <= final_seen_d;
        end
    end

    // Job address/length (reloaded at every job start, no reset needed)
    always_ff @(posedge aclk) begin
        vaddr_q <= vaddr_d;
        len_q   <= len_d;
    end

endmodule

// File: tb/tb_stream_reader.sv
// -----------------------------------------------------------------------------
// Testbench for stream_reader (instantiated with MAX_OUTSTANDING=2 so the
// request-window stall is reachable with short jobs). Expected requests and
// data beats are queued when stimulus is driven and compared by a monitor
// when the DUT hands them over.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_reader;

    localparam int          VB   = 48;
    localparam logic [3:0]  DEST = 4'd0;
    localparam logic [4:0]  OPC  = 5'd1;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [VB-1:0] i_vaddr = '0;
    logic [VB-1:0] i_len = '0;
    logic          i_job_valid = 1'b0;
    logic          o_job_ready;
    logic [VB-1:0] o_bytes_read;
    logic          o_busy;

    always #5 aclk = ~aclk;

    metaIntf #(.VADDR_BITS(VB)) sq_rd ();
    metaIntf #(.VADDR_BITS(VB)) cq_rd ();
    metaIntf #(.VADDR_BITS(VB)) notify ();
    AXI4S i_data ();
    AXI4S o_data ();

    stream_reader #(.MAX_OUTSTANDING(2), .VADDR_BITS(VB)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .i_vaddr      (i_vaddr),
        .i_len        (i_len),
        .i_job_valid  (i_job_valid),
        .o_job_ready  (o_job_ready),
        .o_bytes_read (o_bytes_read),
        .o_busy       (o_busy),
        .sq_rd        (sq_rd),
        .cq_rd        (cq_rd),
        .notify       (notify),
        .i_data       (i_data),
        .o_data       (o_data)
    );

    typedef struct packed { logic [VB-1:0] vaddr; logic [27:0] len; } req_t;
    typedef struct packed { logic [63:0] data; logic last; } beat_t;

    req_t          req_q[$];
    beat_t         beat_q[$];
    int            checks = 0;
    int            errors = 0;
    int            req_seen = 0;
    int            beats_seen = 0;
    logic [VB-1:0] exp_bytes = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: handshakes are stable at the falling edge
    always @(negedge aclk) begin
        req_t  r;
        beat_t b;
        if (aresetn && sq_rd.valid && sq_rd.ready) begin
            req_seen++;
            check("req_pending", 64'(req_q.size() > 0), 64'd1);
            if (req_q.size() > 0) begin
                r = req_q.pop_front();
                check("req_vaddr", sq_rd.vaddr, r.vaddr);
                check("req_len", sq_rd.len, r.len);
                check("req_opcode", sq_rd.opcode, OPC);
                check("req_fields", {sq_rd.dest, sq_rd.strm, sq_rd.pid, sq_rd.mode,
                                     sq_rd.rdma, sq_rd.remote, sq_rd.last},
                      {DEST, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1});
            end
        end
        if (aresetn && o_data.tvalid && o_data.tready) begin
            beats_seen++;
            check("beat_pending", 64'(beat_q.size() > 0), 64'd1);
            if (beat_q.size() > 0) begin
                b = beat_q.pop_front();
                check("beat_data", o_data.tdata[63:0], b.data);
                check("beat_last", o_data.tlast, b.last);
            end
        end
    end

    task automatic cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic push_reqs(input logic [VB-1:0] va, input logic [VB-1:0] len);
        logic [VB-1:0] a   = va;
        logic [VB-1:0] rem = len;
        logic [VB-1:0] l;
        while (rem != '0) begin
            l = (rem > 48'd4096) ? 48'd4096 : rem;
            req_q.push_back('{vaddr: a, len: 28'(l)});
            a   += l;
            rem -= l;
        end
    endtask

    task automatic start_job(input logic [VB-1:0] va, input logic [VB-1:0] len);
        bit got = 1'b0;
        i_vaddr = va;
        i_len = len;
        i_job_valid = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge aclk);
            if (o_job_ready) got = 1'b1;
        end
        check("job_accept", got, 1);
        cycle();
        i_job_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] keep, input bit last_exp, input bit with_cpl);
        logic [63:0] d = {$urandom, $urandom};
        bit got = 1'b0;
        i_data.tdata  = {8{d}};
        i_data.tkeep  = keep;
        i_data.tlast  = 1'($urandom);
        i_data.tvalid = 1'b1;
        beat_q.push_back('{data: d, last: last_exp});
        exp_bytes += VB'($countones(keep));
        if (with_cpl) begin
            cq_rd.valid = 1'b1;
            cq_rd.dest  = DEST;
        end
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge aclk);
            if (i_data.tready) got = 1'b1;
        end
        check("beat_accept", got, 1);
        cycle();
        i_data.tvalid = 1'b0;
        i_data.tlast  = 1'b0;
        cq_rd.valid   = 1'b0;
    endtask

    task automatic send_cpl(input logic [3:0] dest);
        cq_rd.valid = 1'b1;
        cq_rd.dest  = dest;
        cycle();
        cq_rd.valid = 1'b0;
    endtask

    // Called one cycle after the edge on which DRAIN should have exited
    task automatic check_exit(input string tag);
`ifdef STREAM_READER_NOTIFY_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check({tag, "_notify_hold"}, notify.valid, 1);
            check({tag, "_notify_value"}, notify.value, 72);
            check({tag, "_notify_busy"}, o_busy, 1);
            cycle();
        end
        notify.ready = 1'b1;
        @(negedge aclk);
        check({tag, "_notify_fire"}, notify.valid, 1);
        cycle();
        notify.ready = 1'b0;
        #2;
        check({tag, "_idle"}, o_busy, 0);
`else
        #2;
        check({tag, "_idle"}, o_busy, 0);
        check({tag, "_notify_off"}, notify.valid, 0);
`endif
    endtask

    initial begin
        int base;
        sq_rd.ready   = 1'b1;
        notify.ready  = 1'b0;
        o_data.tready = 1'b1;
        i_data.tdata  = '0;
        i_data.tkeep  = '0;
        i_data.tlast  = 1'b0;
        i_data.tvalid = 1'b0;
        cq_rd.valid   = 1'b0;
        cq_rd.opcode  = OPC;
        cq_rd.strm    = 2'd0;
        cq_rd.dest    = DEST;
        cq_rd.pid     = '0;
        cq_rd.mode    = 1'b0;
        cq_rd.rdma    = 1'b0;
        cq_rd.remote  = 1'b0;
        cq_rd.last    = 1'b1;
        cq_rd.vaddr   = '0;
        cq_rd.len     = '0;
        cq_rd.value   = '0;

        idle_cycles(3);
        aresetn = 1'b1;
        cycle();
        #2;
        check("rst_busy", o_busy, 0);
        check("rst_job_ready", o_job_ready, 1);
        check("rst_bytes", o_bytes_read, 0);
        check("rst_sq_valid", sq_rd.valid, 0);
        check("rst_notify_valid", notify.valid, 0);
        check("rst_tvalid", o_data.tvalid, 0);
        check("rst_idle_tready", i_data.tready, 0);
        check("cq_ready_tied", cq_rd.ready, 1);

        // Single 4 KiB request, mismatched completion ignored while draining
        push_reqs(48'h1000, 48'd4096);
        base = req_seen;
        start_job(48'h1000, 48'd4096);
        for (int i = 0; i < 64; i++) send_beat('1, (i == 63), 1'b0);
        idle_cycles(2);
        #2;
        check("s1_wait_cpl", o_busy, 1);
        send_cpl(DEST ^ 4'd1);
        idle_cycles(3);
        #2;
        check("s1_bad_dest_ignored", o_busy, 1);
        send_cpl(DEST);
        check_exit("s1");
        check("s1_reqs", req_seen - base, 1);
        check("s1_bytes", o_bytes_read, exp_bytes);

        // Half-filled beats: tlast follows the byte count, not the beat count
        push_reqs(48'h8000, 48'd128);
        start_job(48'h8000, 48'd128);
        for (int i = 0; i < 4; i++) send_beat(64'h0000_0000_FFFF_FFFF, (i == 3), 1'b0);
        send_cpl(DEST);
        check_exit("s5");
        check("s5_bytes", o_bytes_read, exp_bytes);

        // 10 KiB split in three, window of 2, last completion with last beat
        push_reqs(48'h1000, 48'd10240);
        base = req_seen;
        beats_seen = 0;
        start_job(48'h1000, 48'd10240);
        for (int i = 0; i < 160; i++) begin
            send_beat('1, (i == 159), (i == 19) || (i == 39) || (i == 159));
            if (i == 10) begin
                #2;
                check("s2_window_reqs", req_seen - base, 2);
                check("s2_window_stall", sq_rd.valid, 0);
            end
        end
        check_exit("s2");
        check("s2_reqs", req_seen - base, 3);
        check("s2_beats", beats_seen, 160);
        check("s2_bytes", o_bytes_read, exp_bytes);

        // Window full with completions withheld; data still flows
        push_reqs(48'h10000, 48'd16384);
        base = req_seen;
        start_job(48'h10000, 48'd16384);
        idle_cycles(5);
        #2;
        check("s3_reqs_capped", req_seen - base, 2);
        check("s3_sq_stalled", sq_rd.valid, 0);
        send_cpl(DEST ^ 4'd1);
        idle_cycles(3);
        #2;
        check("s3_bad_dest_no_issue", req_seen - base, 2);
        for (int i = 0; i < 10; i++) send_beat('1, 1'b0, 1'b0);
        check("s3_bytes_flow", o_bytes_read, exp_bytes);

        // Reset mid-job after 10 beats
        aresetn = 1'b0;
        i_data.tvalid = 1'b1;
        cycle();
        #2;
        check("s6_busy", o_busy, 0);
        check("s6_job_ready", o_job_ready, 1);
        check("s6_bytes", o_bytes_read, 0);
        check("s6_sq_valid", sq_rd.valid, 0);
        check("s6_tvalid", o_data.tvalid, 0);
        req_q.delete();
        beat_q.delete();
        exp_bytes = '0;
        aresetn = 1'b1;
        i_data.tvalid = 1'b0;
        cycle();
        send_cpl(DEST);
        idle_cycles(1);
        #2;
        check("s6_stray_idle", o_busy, 0);
        push_reqs(48'h20000, 48'd16384);
        base = req_seen;
        start_job(48'h20000, 48'd16384);
        idle_cycles(5);
        #2;
        check("s6_outstanding_zero", req_seen - base, 2);

        aresetn = 1'b0;
        idle_cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
